// File: rtl/des_key_dispatch_if.sv
// des_key_dispatch_if: bus between the search controller / engines and the key dispatcher.
// master: start, key_base, key_limit, eng_busy, eng_found. slave: load, key_out, result_sel, active, done, found.
interface des_key_dispatch_if #(
   parameter int N_ENG = 16,
   parameter int KEY_W = 64
);
   logic                         start;
   logic [KEY_W-1:0]             key_base;
   logic [KEY_W-1:0]             key_limit;
   logic [N_ENG-1:0]             eng_busy;
   logic [N_ENG-1:0]             eng_found;
   logic [N_ENG-1:0]             load;
   logic [N_ENG-1:0][KEY_W-1:0]  key_out;
   logic [N_ENG-1:0]             result_sel;
   logic                         active;
   logic                         done;
   logic                         found;

   modport master (
      output start, key_base, key_limit, eng_busy, eng_found,
      input  load, key_out, result_sel, active, done, found
   );

   modport slave (
      input  start, key_base, key_limit, eng_busy, eng_found,
      output load, key_out, result_sel, active, done, found
   );
endinterface

// File: rtl/des_key_dispatch.sv
// des_key_dispatch: walks [key_base, key_limit] handing one key per cycle to free DES engines.
// Ports: clk, reset (async, active-high), bus (slave side of des_key_dispatch_if).
module des_key_dispatch #(
   parameter int N_ENG = 16,
   parameter int KEY_W = 64
) (
   input  logic            clk,
   input  logic            reset,
   des_key_dispatch_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      DRAIN,
      FOUND,
      EXHAUSTED
   } state_t;

   state_t                      state;
   state_t                      state_nx;
   logic [N_ENG-1:0]            ptr;
   logic [N_ENG-1:0]            load_q;
   logic [N_ENG-1:0]            sel_q;
   logic [N_ENG-1:0][KEY_W-1:0] key_q;
   logic [KEY_W-1:0]            next_key;
   logic [KEY_W-1:0]            limit_q;
   logic [N_ENG-1:0]            first_found;
   logic                        go;
   logic                        hit;
   logic                        issue;
   logic                        last;
   logic                        drained;

   // isolate lowest set bit: fixed priority to engine 0
   assign first_found = bus.eng_found & (~bus.eng_found + N_ENG'(1));

   assign go = bus.start &&
               (state == IDLE || state == FOUND || state == EXHAUSTED);
   assign hit = (state == DISPATCH || state == DRAIN) && (|bus.eng_found);
   assign issue = (state == DISPATCH) && !hit && !(|(bus.eng_busy & ptr));
   assign last = issue && (next_key == limit_q);
   // a load still on the wire means that engine has not yet raised busy
   assign drained = (bus.eng_busy == '0) && (load_q == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, FOUND, EXHAUSTED: begin
            if (bus.start)
               state_nx = (bus.key_base <= bus.key_limit) ? DISPATCH : EXHAUSTED;
         end
         DISPATCH: begin
            if (hit)       state_nx = FOUND;
            else if (last) state_nx = DRAIN;
         end
         DRAIN: begin
            if (hit)          state_nx = FOUND;
            else if (drained) state_nx = EXHAUSTED;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.active = 1'b0;
      bus.done   = 1'b0;
      bus.found  = 1'b0;
      unique case (state)
         DISPATCH, DRAIN: bus.active = 1'b1;
         FOUND: begin
            bus.done  = 1'b1;
            bus.found = 1'b1;
         end
         EXHAUSTED: bus.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= N_ENG'(1);
         load_q   <= '0;
         sel_q    <= '0;
         key_q    <= '0;
         next_key <= '0;
         limit_q  <= '0;
      end else begin
         load_q <= issue ? ptr : '0;
         for (int i = 0; i < N_ENG; i++)
            if (issue && ptr[i]) key_q[i] <= next_key;
         // on the last key the increment is dropped so the range never wraps
         if (issue && !last) next_key <= next_key + KEY_W'(1);
         if (state == DISPATCH) ptr <= {ptr[N_ENG-2:0], ptr[N_ENG-1]};
         if (go) begin
            next_key <= bus.key_base;
            limit_q  <= bus.key_limit;
            sel_q    <= '0;
         end
         if (hit) sel_q <= first_found;
      end
   end

   assign bus.load       = load_q;
   assign bus.key_out    = key_q;
   assign bus.result_sel = sel_q;

endmodule

// File: tb/tb_des_key_dispatch.sv
// tb_des_key_dispatch: randomized and directed checks of des_key_dispatch against a behavioural model.
// Emulates engines that go busy the cycle after a load and stay busy for a chosen time.
module tb_des_key_dispatch;
   localparam int N  = 16;
   localparam int KW = 64;

   typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_HIT, M_EXH} mode_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   des_key_dispatch_if #(.N_ENG(N), .KEY_W(KW)) bus ();
   des_key_dispatch #(.N_ENG(N), .KEY_W(KW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   mode_t         m_mode;
   int            m_ptr;
   logic [KW-1:0] m_next;
   logic [KW-1:0] m_lim;
   logic [N-1:0]  m_load;
   logic [N-1:0]  m_sel;
   logic [KW-1:0] m_key [N];

   int            busy_cnt [N];
   logic [N-1:0]  pend;
   logic [N-1:0]  force_busy;
   int            dur = 20;
   bit            dur_rand = 1'b0;
   bit            rnd_found = 1'b0;
   int            nloads = 0;
   logic [N-1:0]  lq [$];

   function automatic void model_reset();
      m_mode = M_IDLE;
      m_ptr  = 0;
      m_next = '0;
      m_lim  = '0;
      m_load = '0;
      m_sel  = '0;
      for (int i = 0; i < N; i++) m_key[i] = '0;
   endfunction

   function automatic void model_step();
      mode_t        old = m_mode;
      logic [N-1:0] nl  = '0;
      int           lo  = 0;
      bit           srch = (old == M_RUN) || (old == M_DRAIN);
      if ((old == M_IDLE || old == M_HIT || old == M_EXH) && bus.start) begin
         m_next = bus.key_base;
         m_lim  = bus.key_limit;
         m_sel  = '0;
         m_mode = (bus.key_base <= bus.key_limit) ? M_RUN : M_EXH;
      end else if (srch && bus.eng_found != '0) begin
         for (int i = N - 1; i >= 0; i--) if (bus.eng_found[i]) lo = i;
         m_sel = '0;
         m_sel[lo] = 1'b1;
         m_mode = M_HIT;
      end else if (old == M_RUN) begin
         if (!bus.eng_busy[m_ptr]) begin
            nl[m_ptr] = 1'b1;
            m_key[m_ptr] = m_next;
            if (m_next == m_lim) m_mode = M_DRAIN;
            else m_next = m_next + 1;
         end
      end else if (old == M_DRAIN && bus.eng_busy == '0 && m_load == '0) begin
         m_mode = M_EXH;
      end
      if (old == M_RUN) m_ptr = (m_ptr + 1) % N;
      m_load = nl;
   endfunction

   task automatic cmp(input string n, input logic [KW-1:0] act,
                      input logic [KW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", n, act, exp);
      end
   endtask

   task automatic check_all();
      cmp("load", KW'(bus.load), KW'(m_load));
      cmp("result_sel", KW'(bus.result_sel), KW'(m_sel));
      cmp("active", KW'(bus.active), KW'(m_mode == M_RUN || m_mode == M_DRAIN));
      cmp("done", KW'(bus.done), KW'(m_mode == M_HIT || m_mode == M_EXH));
      cmp("found", KW'(bus.found), KW'(m_mode == M_HIT));
      for (int i = 0; i < N; i++)
         cmp($sformatf("key_out[%0d]", i), bus.key_out[i], m_key[i]);
   endtask

   task automatic drive_busy();
      logic [N-1:0] b;
      b = force_busy;
      for (int i = 0; i < N; i++) if (busy_cnt[i] > 0) b[i] = 1'b1;
      bus.eng_busy = b;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!reset) model_step();
      #1;
      check_all();
      for (int i = 0; i < N; i++) begin
         if (busy_cnt[i] > 0) busy_cnt[i]--;
         if (pend[i]) busy_cnt[i] = dur_rand ? int'($urandom_range(1, 30)) : dur;
      end
      pend = bus.load;
      if (bus.load != '0) begin
         nloads++;
         lq.push_back(bus.load);
      end
      drive_busy();
      if (rnd_found) begin
         if (m_mode == M_RUN || m_mode == M_DRAIN)
            bus.eng_found = ($urandom_range(0, 59) == 0) ?
                            N'($urandom_range(1, 65535)) : '0;
         else
            bus.eng_found = N'($urandom);
      end
   endtask

   task automatic clear_stim();
      for (int i = 0; i < N; i++) busy_cnt[i] = 0;
      pend          = '0;
      force_busy    = '0;
      bus.eng_busy  = '0;
      bus.eng_found = '0;
      bus.start     = 1'b0;
      lq.delete();
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      model_reset();
      clear_stim();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
   endtask

   task automatic launch(input logic [KW-1:0] b, input logic [KW-1:0] l);
      bus.key_base  = b;
      bus.key_limit = l;
      bus.eng_found = '0;
      bus.start     = 1'b1;
      cyc();
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!bus.done && k < budget) begin
         cyc();
         k++;
      end
      cmp("wait_done", KW'(bus.done), KW'(1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bus.start     = 1'b0;
      bus.key_base  = '0;
      bus.key_limit = '0;
      bus.eng_busy  = '0;
      bus.eng_found = '0;
      pend          = '0;
      force_busy    = '0;
      #1;
      hard_reset();
      cmp("reset_active", KW'(bus.active), KW'(0));
      cmp("reset_load", KW'(bus.load), KW'(0));

      // idle engines, simple range
      dur = 20;
      launch(KW'(64'h10), KW'(64'h13));
      cmp("t1_active", KW'(bus.active), KW'(1));
      wait_done(100);
      cmp("t1_found", KW'(bus.found), KW'(0));
      cmp("t1_sel", KW'(bus.result_sel), KW'(0));
      cmp("t1_nload", KW'(lq.size()), KW'(4));
      if (lq.size() == 4) begin
         cmp("t1_ld0", KW'(lq[0]), KW'(16'h0001));
         cmp("t1_ld1", KW'(lq[1]), KW'(16'h0002));
         cmp("t1_ld2", KW'(lq[2]), KW'(16'h0004));
         cmp("t1_ld3", KW'(lq[3]), KW'(16'h0008));
      end
      cmp("t1_k0", bus.key_out[0], KW'(64'h10));
      cmp("t1_k3", bus.key_out[3], KW'(64'h13));

      // busy skip
      hard_reset();
      force_busy = 16'h0002;
      drive_busy();
      launch(KW'(0), KW'(2));
      repeat (8) cyc();
      force_busy = '0;
      wait_done(100);
      cmp("t2_nload", KW'(lq.size()), KW'(3));
      if (lq.size() == 3) begin
         cmp("t2_ld0", KW'(lq[0]), KW'(16'h0001));
         cmp("t2_ld1", KW'(lq[1]), KW'(16'h0004));
         cmp("t2_ld2", KW'(lq[2]), KW'(16'h0008));
      end
      cmp("t2_k1", bus.key_out[1], KW'(0));
      cmp("t2_k2", bus.key_out[2], KW'(1));
      cmp("t2_k3", bus.key_out[3], KW'(2));

      // simultaneous match
      dur = 40;
      launch(KW'(64'h100), KW'(64'h1FF));
      repeat (5) cyc();
      bus.eng_found = 16'h0120;
      cyc();
      cmp("t3_found", KW'(bus.found), KW'(1));
      cmp("t3_done", KW'(bus.done), KW'(1));
      cmp("t3_sel", KW'(bus.result_sel), KW'(16'h0020));
      cmp("t3_load", KW'(bus.load), KW'(0));
      n0 = nloads;
      bus.eng_found = 16'h0003;
      repeat (5) cyc();
      bus.eng_found = '0;
      cmp("t3_noload", KW'(nloads), KW'(n0));
      cmp("t3_sel_hold", KW'(bus.result_sel), KW'(16'h0020));

      // empty range
      lq.delete();
      launch(KW'(64'h20), KW'(64'h1F));
      cmp("t4_done", KW'(bus.done), KW'(1));
      cmp("t4_found", KW'(bus.found), KW'(0));
      cmp("t4_sel", KW'(bus.result_sel), KW'(0));
      repeat (4) cyc();
      cmp("t4_nload", KW'(lq.size()), KW'(0));

      // no wrap at top of range
      hard_reset();
      dur = 3;
      launch(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done(100);
      repeat (4) cyc();
      cmp("t5_nload", KW'(lq.size()), KW'(2));
      cmp("t5_k0", bus.key_out[0], 64'hFFFF_FFFF_FFFF_FFFE);
      cmp("t5_k1", bus.key_out[1], 64'hFFFF_FFFF_FFFF_FFFF);
      cmp("t5_k2", bus.key_out[2], KW'(0));

      // reset mid-search
      hard_reset();
      dur = 10;
      launch(KW'(64'h500), KW'(64'h5FF));
      repeat (6) cyc();
      #3;
      reset = 1'b1;
      #1;
      cmp("t6_load", KW'(bus.load), KW'(0));
      cmp("t6_active", KW'(bus.active), KW'(0));
      cmp("t6_k0", bus.key_out[0], KW'(0));
      cmp("t6_k1", bus.key_out[1], KW'(0));
      cmp("t6_done", KW'(bus.done), KW'(0));
      hard_reset();
      launch(KW'(64'h40), KW'(64'h42));
      wait_done(200);
      cmp("t6_newk0", bus.key_out[0], KW'(64'h40));
      cmp("t6_newk2", bus.key_out[2], KW'(64'h42));

      // randomized searches with spurious starts, matches and engine timing
      dur_rand  = 1'b1;
      rnd_found = 1'b1;
      for (int it = 0; it < 40; it++) begin
         logic [KW-1:0] b;
         logic [KW-1:0] l;
         int k;
         b = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) begin
            b = '1;
            b = b - KW'($urandom_range(0, 5));
            l = '1;
         end else if ($urandom_range(0, 7) == 0) begin
            l = b - KW'($urandom_range(1, 3));
         end else begin
            l = b + KW'($urandom_range(0, 30));
         end
         launch(b, l);
         k = 0;
         while (!bus.done && k < 3000) begin
            bus.start = ($urandom_range(0, 19) == 0);
            bus.key_base = {$urandom, $urandom};
            cyc();
            k++;
         end
         bus.start = 1'b0;
         cmp("rnd_done", KW'(bus.done), KW'(1));
         repeat ($urandom_range(0, 5)) cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
